ds1302_time_scheduler: RTL

- Sequencer in front of the DS1302 all-time read/write block; the only source of its set_trig/get_trig/bcd_time_set.
- Polls the RTC periodically and arbitrates user set requests against polls. Set wins.
- Publishes a stable latched time, a valid flag and a per-second tick.
- The downstream block has no done output, so completion is timed by a fixed guard count.

---
 rtl/ds1302_time_scheduler_if.sv | 10 +
 rtl/ds1302_time_scheduler.sv | 121 ++++++++++++
 2 files changed

// File: rtl/ds1302_time_scheduler_if.sv
// Set-request channel between a requester and the DS1302 time scheduler.
// set_ack pulses in the cycle set_time is latched.
interface ds1302_time_scheduler_if;
   logic        set_req;
   logic [55:0] set_time;
   logic        set_ack;

   modport master (output set_req, output set_time, input set_ack);
   modport slave  (input set_req, input set_time, output set_ack);
endinterface

// File: rtl/ds1302_time_scheduler.sv
// Sequencer in front of the DS1302 all-time read/write block: periodic polls, set-wins
// arbitration, guard-timed completion, and a latched time with valid flag and second tick.
module ds1302_time_scheduler #(
   parameter int POLL_PERIOD    = 5_000_000,
   parameter int OP_WAIT_CYCLES = 33_000
) (
   input  logic                        sclk,
   input  logic                        rst,
   input  logic                        poll_en,
   ds1302_time_scheduler_if.slave      req,
   output logic                        set_trig,
   output logic                        get_trig,
   output logic [63:0]                 bcd_time_set,
   input  logic [63:0]                 bcd_time_get,
   output logic [55:0]                 time_bcd,
   output logic                        wp_flag,
   output logic                        time_valid,
   output logic                        sec_tick,
   output logic                        busy
);
   localparam int PW = $clog2(POLL_PERIOD);
   localparam int WW = $clog2(OP_WAIT_CYCLES);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] SET_FIRE = 3'd1;
   localparam logic [2:0] SET_WAIT = 3'd2;
   localparam logic [2:0] GET_FIRE = 3'd3;
   localparam logic [2:0] GET_WAIT = 3'd4;
   localparam logic [2:0] CAPTURE  = 3'd5;

   logic [2:0]    state_reg;
   logic [PW-1:0] poll_cnt_reg;
   logic          poll_pending_reg;
   logic [WW-1:0] wait_cnt_reg;
   logic          poll_wrap;
   logic          wait_done;
   logic          set_done;
   logic          unused_bits;

   assign poll_wrap = poll_en && (poll_cnt_reg == PW'(POLL_PERIOD - 1));
   assign wait_done = (wait_cnt_reg == WW'(OP_WAIT_CYCLES - 1));
   assign set_done  = (state_reg == SET_WAIT) && wait_done;

   // Triggers and ack decode straight from state so the two triggers can never coincide.
   assign set_trig    = (state_reg == SET_FIRE);
   assign get_trig    = (state_reg == GET_FIRE);
   assign busy        = (state_reg != IDLE);
   assign req.set_ack = (state_reg == IDLE) && req.set_req && !rst;
   assign unused_bits = ^bcd_time_get[62:56];

   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         poll_cnt_reg     <= '0;
         poll_pending_reg <= 1'b1;
      end else if (set_done) begin
         // The mandatory read-back stands in for the next poll, so restart the period.
         poll_cnt_reg     <= '0;
         poll_pending_reg <= 1'b0;
      end else begin
         if (poll_en)
            poll_cnt_reg <= poll_wrap ? '0 : poll_cnt_reg + PW'(1);
         if (poll_wrap)
            poll_pending_reg <= 1'b1;
         else if (state_reg == GET_FIRE)
            poll_pending_reg <= 1'b0;
      end
   end

   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         wait_cnt_reg <= '0;
         bcd_time_set <= '0;
         time_bcd     <= '0;
         wp_flag      <= 1'b0;
         time_valid   <= 1'b0;
         sec_tick     <= 1'b0;
      end else begin
         sec_tick <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (req.set_req) begin
                  bcd_time_set <= {8'h00, req.set_time};
                  state_reg    <= SET_FIRE;
               end else if (poll_pending_reg) begin
                  state_reg <= GET_FIRE;
               end
            end
            SET_FIRE: begin
               wait_cnt_reg <= '0;
               state_reg    <= SET_WAIT;
            end
            SET_WAIT: begin
               if (wait_done)
                  state_reg <= GET_FIRE;
               else
                  wait_cnt_reg <= wait_cnt_reg + WW'(1);
            end
            GET_FIRE: begin
               wait_cnt_reg <= '0;
               state_reg    <= GET_WAIT;
            end
            GET_WAIT: begin
               if (wait_done)
                  state_reg <= CAPTURE;
               else
                  wait_cnt_reg <= wait_cnt_reg + WW'(1);
            end
            CAPTURE: begin
               time_bcd   <= bcd_time_get[55:0];
               wp_flag    <= bcd_time_get[63];
               time_valid <= 1'b1;
               // CH (seconds bit 7) is excluded so halting the oscillator never ticks.
               sec_tick   <= time_valid && (bcd_time_get[6:0] != time_bcd[6:0]);
               state_reg  <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule
